ghost_collision_ctrl: RTL

Game-state controller that closes the loop around the ghost sprite blocks. It watches per-pixel sprite `on` flags from Yoshi and both ghosts during each frame and latches any overlap. It then runs the IDLE/PLAYING/HIT/GAMEOVER state machine, counts lives and score, and produces the registered `speed_offset` that the ghost movement blocks consume to shorten their position-update period.

---
 rtl/ghost_collision_ctrl_pkg.sv | 27 ++
 rtl/ghost_collision_ctrl_collision_latch.sv | 33 +++
 rtl/ghost_collision_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ghost_collision_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ghost_collision_ctrl_pkg
// Description : Shared game definitions: state encodings and ghost speed widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ghost_collision_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PLAYING  = 2'd1;
    localparam logic [1:0] ST_HIT      = 2'd2;
    localparam logic [1:0] ST_GAMEOVER = 2'd3;

    localparam int GHOST_TIME_MAX = 4600000;
    localparam int SPEED_W        = 26;
    localparam int SCORE_W        = 14;
    localparam int LIVES_W        = 2;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] value,
        input logic [SCORE_W-1:0] limit
    );
        return (value >= limit) ? limit : value + SCORE_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_collision_ctrl_collision_latch.sv
`default_nettype none
// ============================================================================
// Module      : collision_latch
// Description : Per-frame sticky OR of collision pixels, restarted on frame_start.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_latch
    import ghost_collision_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    input  logic coll_now,
    output logic latched
);

    logic r_latch;

    // A hit on the frame_start pixel seeds the new frame, never the old one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_latch <= 1'b0;
        end else if (frame_start) begin
            r_latch <= coll_now;
        end else begin
            r_latch <= r_latch | coll_now;
        end
    end

    assign latched = r_latch;

endmodule
`default_nettype wire

// File: rtl/ghost_collision_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ghost_collision_ctrl
// Description : Game FSM, lives/score bookkeeping and ghost speed offset.
// Revision    : 1.0 - initial release
// ============================================================================
module ghost_collision_ctrl
    import ghost_collision_ctrl_pkg::*;
#(
    parameter int START_LIVES   = 3,
    parameter int SCORE_DIV     = 60,
    parameter int SCORE_MAX     = 9999,
    parameter int SPEED_STEP    = 2000,
    parameter int SPEED_MAX     = 3000000,
    parameter int INVULN_FRAMES = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               video_on,
    input  logic               yoshi_on,
    input  logic               ghost_top_on,
    input  logic               ghost_bottom_on,
    input  logic               start_btn,
    output logic [1:0]         game_state,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [SPEED_W-1:0] speed_offset,
    output logic               hit_flash
);

    localparam int c_FCNT_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int c_INV_W  = (INVULN_FRAMES > 8) ? $clog2(INVULN_FRAMES) : 3;

    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST   = c_FCNT_W'(SCORE_DIV - 1);
    localparam logic [c_INV_W-1:0]  c_INV_LOAD    = c_INV_W'(INVULN_FRAMES - 1);
    localparam logic [LIVES_W-1:0]  c_START_LIVES = LIVES_W'(START_LIVES);
    localparam logic [SCORE_W-1:0]  c_SCORE_MAX   = SCORE_W'(SCORE_MAX);
    localparam logic [SPEED_W-1:0]  c_SPEED_STEP  = SPEED_W'(SPEED_STEP);
    localparam logic [SPEED_W-1:0]  c_SPEED_MAX   = SPEED_W'(SPEED_MAX);

    logic                r_btn_q;
    logic                r_start_pulse;
    logic [1:0]          r_state;
    logic [LIVES_W-1:0]  r_lives;
    logic [SCORE_W-1:0]  r_score;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic [c_INV_W-1:0]  r_inv;
    logic [SPEED_W-1:0]  r_speed;
    logic                r_hit_flash;

    logic                w_coll_now;
    logic                w_latched;
    logic                w_scoring;
    logic [1:0]          w_state_nxt;
    logic [LIVES_W-1:0]  w_lives_nxt;
    logic [SCORE_W-1:0]  w_score_nxt;
    logic [c_FCNT_W-1:0] w_fcnt_nxt;
    logic [c_INV_W-1:0]  w_inv_nxt;
    logic                w_flash_nxt;
    logic [SPEED_W-1:0]  w_prod;

    assign w_coll_now = video_on & yoshi_on & (ghost_top_on | ghost_bottom_on);

    collision_latch u_collision_latch (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .coll_now    (w_coll_now),
        .latched     (w_latched)
    );

    assign w_scoring = frame_start & ((r_state == ST_PLAYING) | (r_state == ST_HIT));

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        w_fcnt_nxt  = r_fcnt;
        w_inv_nxt   = r_inv;

        // Scoring runs ahead of the FSM so a game-ending frame still counts.
        if (w_scoring) begin
            if (r_fcnt == c_FCNT_LAST) begin
                w_fcnt_nxt  = '0;
                w_score_nxt = sat_inc(r_score, c_SCORE_MAX);
            end else begin
                w_fcnt_nxt = r_fcnt + c_FCNT_W'(1);
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (r_start_pulse) begin
                    w_state_nxt = ST_PLAYING;
                    w_lives_nxt = c_START_LIVES;
                    w_score_nxt = '0;
                    w_fcnt_nxt  = '0;
                    w_inv_nxt   = '0;
                end
            end
            ST_PLAYING: begin
                if (frame_start && w_latched) begin
                    if (r_lives <= LIVES_W'(1)) begin
                        w_lives_nxt = '0;
                        w_state_nxt = ST_GAMEOVER;
                    end else begin
                        w_lives_nxt = r_lives - LIVES_W'(1);
                        w_inv_nxt   = c_INV_LOAD;
                        w_state_nxt = ST_HIT;
                    end
                end
            end
            ST_HIT: begin
                if (frame_start) begin
                    if (r_inv == '0) begin
                        w_state_nxt = ST_PLAYING;
                    end else begin
                        w_inv_nxt = r_inv - c_INV_W'(1);
                    end
                end
            end
            ST_GAMEOVER: begin
                if (r_start_pulse) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_flash_nxt = (w_state_nxt == ST_HIT) & w_inv_nxt[2];
    end

    // Product fits in 26 bits for every legal score, so only the ceiling needs a compare.
    assign w_prod = SPEED_W'(r_score) * c_SPEED_STEP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_q       <= 1'b0;
            r_start_pulse <= 1'b0;
            r_state       <= ST_IDLE;
            r_lives       <= '0;
            r_score       <= '0;
            r_fcnt        <= '0;
            r_inv         <= '0;
            r_speed       <= '0;
            r_hit_flash   <= 1'b0;
        end else begin
            r_btn_q       <= start_btn;
            r_start_pulse <= start_btn & ~r_btn_q;
            r_state       <= w_state_nxt;
            r_lives       <= w_lives_nxt;
            r_score       <= w_score_nxt;
            r_fcnt        <= w_fcnt_nxt;
            r_inv         <= w_inv_nxt;
            r_speed       <= (w_prod > c_SPEED_MAX) ? c_SPEED_MAX : w_prod;
            r_hit_flash   <= w_flash_nxt;
        end
    end

    assign game_state   = r_state;
    assign lives        = r_lives;
    assign score        = r_score;
    assign speed_offset = r_speed;
    assign hit_flash    = r_hit_flash;

endmodule
`default_nettype wire
